// File: rtl/rv_alu_issue.sv
// Issue/write-back unit for the RV32I ALU: decodes R/I-type ALU ops, reads the
// register file with single-cycle forwarding, and writes ALU results back.
module rv_alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [2:0]  alu_f3,
  output logic [6:0]  alu_f7,
  output logic [6:0]  alu_opcode,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal,
  output logic [31:0] retired,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  logic [XLEN-1:0] regs [NREGS];

  logic            e_valid;
  logic [4:0]      e_rd;
  logic [XLEN-1:0] e_in1;
  logic [XLEN-1:0] e_in2;
  logic [2:0]      e_f3;
  logic [6:0]      e_f7;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            dec_legal;
  logic [XLEN-1:0] dec_in2;
  logic [6:0]      dec_f7;
  logic            xfer;
  logic            unused_zero;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};

  assign instr_ready = !rst;
  assign xfer        = instr_valid && instr_ready;
  assign unused_zero = alu_zero;

  assign alu_in1    = e_in1;
  assign alu_in2    = e_in2;
  assign alu_f3     = e_f3;
  assign alu_f7     = e_f7;
  assign alu_opcode = e_valid ? OP_R : 7'b0;

  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

  // Operand read; the instruction in E has not written back yet, so bypass it.
  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
    if (e_valid && (e_rd != 5'd0) && (e_rd == rs1)) rs1_val = alu_result;
    if (e_valid && (e_rd != 5'd0) && (e_rd == rs2)) rs2_val = alu_result;
  end

  // Decode into the ALU's R-type encoding; immediates become operand 2.
  always_comb begin
    dec_legal = 1'b0;
    dec_in2   = rs2_val;
    dec_f7    = 7'b0;
    case (opcode)
      OP_R: begin
        dec_f7    = funct7;
        dec_legal = ((funct7 == 7'b0) && (funct3 != 3'b011)) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) dec_in2 = {27'b0, rs2_val[4:0]};
      end
      OP_I: begin
        case (funct3)
          3'b001: begin
            dec_legal = (funct7 == 7'b0);
            dec_in2   = {27'b0, rs2};
          end
          3'b101: begin
            dec_legal = (funct7 == 7'b0) || (funct7 == F7_ALT);
            dec_f7    = funct7;
            dec_in2   = {27'b0, rs2};
          end
          3'b011: begin
            dec_legal = 1'b0;
            dec_in2   = imm_i;
          end
          default: begin
            dec_legal = 1'b1;
            dec_in2   = imm_i;
          end
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // E stage load (fields zeroed when empty so ALU ports read 0) and write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid  <= 1'b0;
      e_rd     <= 5'd0;
      e_in1    <= '0;
      e_in2    <= '0;
      e_f3     <= 3'b0;
      e_f7     <= 7'b0;
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= '0;
      illegal  <= 1'b0;
      retired  <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      illegal  <= xfer && !dec_legal;
      wb_valid <= e_valid;
      if (xfer && dec_legal) begin
        e_valid <= 1'b1;
        e_rd    <= rd;
        e_in1   <= rs1_val;
        e_in2   <= dec_in2;
        e_f3    <= funct3;
        e_f7    <= dec_f7;
      end else begin
        e_valid <= 1'b0;
        e_rd    <= 5'd0;
        e_in1   <= '0;
        e_in2   <= '0;
        e_f3    <= 3'b0;
        e_f7    <= 7'b0;
      end
      if (e_valid) begin
        wb_rd   <= e_rd;
        wb_data <= alu_result;
        retired <= retired + 32'd1;
        if (e_rd != 5'd0) regs[e_rd] <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_rv_alu_issue.sv
// Self-checking bench for rv_alu_issue: directed plan cases plus randomized
// instruction streams checked against an architectural (in-order) model.
module tb_rv_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = 32'h0;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic [2:0]  alu_f3;
  logic [6:0]  alu_f7, alu_opcode;
  logic        alu_zero;
  logic        wb_valid, illegal;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, retired, dbg_data;
  logic [4:0]  dbg_addr = 5'd0;

  int checks = 0;
  int passes = 0;

  typedef struct {
    bit          legal;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] res;
  } exp_t;

  logic [31:0] m_regs [32];
  logic [31:0] m_retired;
  logic [31:0] prog [$];

  rv_alu_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_f3(alu_f3),
    .alu_f7(alu_f7), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .alu_zero(alu_zero), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal), .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // External ALU: unsigned compare for both SLT and SLTU.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'd0:    return f7[5] ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2,
      3'd3:    return {31'b0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_in1, alu_in2, alu_f3, alu_f7);
  assign alu_zero = (alu_result == 32'h0);

  // Architectural step: executes one instruction on the model state.
  task automatic model_step(input logic [31:0] ins, output exp_t e);
    logic [6:0]  op, fr;
    logic [2:0]  f3;
    logic [31:0] rs2v, imm;
    op   = ins[6:0];
    f3   = ins[14:12];
    fr   = ins[31:25];
    imm  = {{20{ins[31]}}, ins[31:20]};
    rs2v = m_regs[ins[24:20]];
    e.rd = ins[11:7];
    e.a  = m_regs[ins[19:15]];
    e.f3 = f3;
    e.f7 = 7'h0;
    e.b  = 32'h0;
    e.legal = 1'b0;
    if (op == 7'h33) begin
      e.legal = (fr == 7'h00 && f3 != 3'd3) || (fr == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.f7 = fr;
      e.b  = (f3 == 3'd1 || f3 == 3'd5) ? (rs2v & 32'd31) : rs2v;
    end else if (op == 7'h13) begin
      if (f3 == 3'd1) begin
        e.legal = (fr == 7'h00);
        e.b = 32'(ins[24:20]);
      end else if (f3 == 3'd5) begin
        e.legal = (fr == 7'h00 || fr == 7'h20);
        e.f7 = fr;
        e.b = 32'(ins[24:20]);
      end else begin
        e.legal = (f3 != 3'd3);
        e.b = imm;
      end
    end
    case (f3)
      3'd0:    e.res = (e.f7 == 7'h20) ? e.a - e.b : e.a + e.b;
      3'd1:    e.res = e.a << e.b;
      3'd2:    e.res = (e.a < e.b) ? 32'd1 : 32'd0;
      3'd4:    e.res = e.a ^ e.b;
      3'd5:    e.res = (e.f7 == 7'h20) ? 32'($signed(e.a) >>> e.b) : e.a >> e.b;
      3'd6:    e.res = e.a | e.b;
      3'd7:    e.res = e.a & e.b;
      default: e.res = 32'h0;
    endcase
    if (e.legal) begin
      m_retired = m_retired + 32'd1;
      if (e.rd != 5'd0) m_regs[e.rd] = e.res;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    int k;
    k   = $urandom_range(0, 9);
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    if (k < 4)
      return {($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
    if (k < 8) begin
      if (f3 == 3'd1) imm[11:5] = ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'h00;
      if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 5) == 0) ? 7'($urandom) :
                                  (($urandom_range(0, 1) == 0) ? 7'h20 : 7'h00);
      return {imm, rs1, f3, rd, 7'h13};
    end
    if (k == 8) return {7'($urandom), rs2, rs1, f3, rd, 7'h33};
    return $urandom;
  endfunction

  // Streams prog back-to-back; checks E-stage ports one cycle and write-back two cycles later.
  task automatic run_prog();
    exp_t exps [$];
    exp_t e;
    int   n;
    n = prog.size();
    for (int c = 0; c <= n + 1; c++) begin
      @(negedge clk);
      checks++;
      if (c >= 1 && c - 1 < n) begin
        e = exps[c-1];
        if (illegal !== !e.legal) $display("FAIL illegal[%0d] got %b expected %b", c-1, illegal, !e.legal);
        else passes++;
        checks++;
        if (e.legal) begin
          if ({alu_in1, alu_in2, alu_f3, alu_f7, alu_opcode} !== {e.a, e.b, e.f3, e.f7, 7'h33})
            $display("FAIL alu_ports[%0d] got %h %h %h %h %h expected %h %h %h %h 33", c-1,
                     alu_in1, alu_in2, alu_f3, alu_f7, alu_opcode, e.a, e.b, e.f3, e.f7);
          else passes++;
        end else begin
          if ({alu_in1, alu_in2, alu_f3, alu_f7, alu_opcode} !== 81'h0)
            $display("FAIL alu_idle[%0d] got %h %h %h %h %h expected zeros", c-1,
                     alu_in1, alu_in2, alu_f3, alu_f7, alu_opcode);
          else passes++;
        end
      end else begin
        if (illegal !== 1'b0) $display("FAIL illegal_idle got %b expected 0", illegal);
        else passes++;
      end
      checks++;
      if (c >= 2) begin
        e = exps[c-2];
        if (wb_valid !== e.legal) $display("FAIL wb_valid[%0d] got %b expected %b", c-2, wb_valid, e.legal);
        else passes++;
        if (e.legal) begin
          checks++;
          if ({wb_rd, wb_data} !== {e.rd, e.res})
            $display("FAIL wb[%0d] got rd=%0d data=%h expected rd=%0d data=%h", c-2, wb_rd, wb_data, e.rd, e.res);
          else passes++;
        end
      end else begin
        if (wb_valid !== 1'b0) $display("FAIL wb_valid_idle got %b expected 0", wb_valid);
        else passes++;
      end
      if (c < n) begin
        model_step(prog[c], e);
        exps.push_back(e);
        instr = prog[c];
        instr_valid = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b1) $display("FAIL instr_ready got %b expected 1", instr_ready);
        else passes++;
      end else begin
        instr_valid = 1'b0;
      end
    end
    prog.delete();
    checks++;
    if (retired !== m_retired) $display("FAIL retired got %h expected %h", retired, m_retired);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_retired = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({instr_ready, wb_valid, wb_rd, wb_data, illegal, retired} !== 72'h0)
      $display("FAIL reset_outputs got rdy=%b wbv=%b rd=%0d data=%h ill=%b ret=%h expected zeros",
               instr_ready, wb_valid, wb_rd, wb_data, illegal, retired);
    else passes++;
    checks++;
    if ({alu_in1, alu_in2, alu_f3, alu_f7, alu_opcode} !== 81'h0)
      $display("FAIL reset_alu got %h %h %h %h %h expected zeros", alu_in1, alu_in2, alu_f3, alu_f7, alu_opcode);
    else passes++;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      checks++;
      if (dbg_data !== 32'h0) $display("FAIL reset_reg x%0d got %h expected 0", i, dbg_data);
      else passes++;
    end
  endtask

  task automatic check_reg(input logic [4:0] r, input logic [31:0] v);
    dbg_addr = r;
    #1;
    checks++;
    if (dbg_data !== v) $display("FAIL dbg x%0d got %h expected %h", r, dbg_data, v);
    else passes++;
  endtask

  task automatic test_basic();
    prog = '{32'h00500093, 32'hFFD00113, 32'h002081B3};
    run_prog();
    check_reg(5'd3, 32'd2);
    checks++;
    if (retired !== 32'd3) $display("FAIL basic_retired got %0d expected 3", retired);
    else passes++;
  endtask

  task automatic test_srai_forward();
    prog = '{32'hFFD00113, 32'h40115213};
    run_prog();
    check_reg(5'd4, 32'hFFFFFFFE);
  endtask

  task automatic test_illegal();
    prog = '{32'h00003033};
    run_prog();
  endtask

  task automatic test_x0_write();
    prog = '{32'h00700013};
    run_prog();
    check_reg(5'd0, 32'h0);
  endtask

  task automatic test_shift_mask();
    prog = '{32'h00100093, 32'h02100293, 32'h00509333};
    run_prog();
    check_reg(5'd6, 32'd2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) prog.push_back(rand_instr());
    run_prog();
    for (int r = 0; r < 32; r++) check_reg(5'(r), m_regs[r]);
  endtask

  task automatic test_idle_gaps();
    for (int i = 0; i < 6; i++) begin
      prog.push_back(rand_instr());
      run_prog();
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    instr = 32'h00900393;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b0) $display("FAIL mid_ready got %b expected 0", instr_ready);
    else passes++;
    @(negedge clk);
    checks++;
    if ({wb_valid, instr_ready, retired} !== 34'h0)
      $display("FAIL mid_reset got wbv=%b rdy=%b ret=%h expected 0 0 0", wb_valid, instr_ready, retired);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0) $display("FAIL mid_wb_valid got %b expected 0", wb_valid);
    else passes++;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_retired = 32'h0;
    check_reg(5'd7, 32'h0);
    checks++;
    if (retired !== 32'h0) $display("FAIL mid_retired got %h expected 0", retired);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_srai_forward();
    test_illegal();
    test_x0_write();
    test_shift_mask();
    test_back_to_back();
    test_idle_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
